// File: rtl/game_sequencer_pkg.sv
// Shared types for the game sequencer: FSM state codes and HUD counter widths.
// Ports: none (package only).
// Imported by the interface, the tick divider's parent and the bench.
package game_pkg;

  localparam int LIVES_W = 3;
  localparam int LEVEL_W = 3;

  // Codes are visible on the state output for the HUD/debug, so keep them fixed.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    NEW_GAME  = 3'd1,
    PLAY      = 3'd2,
    DEATH     = 3'd3,
    WAVE_DONE = 3'd4,
    RESPAWN   = 3'd5,
    GAME_OVER = 3'd6
  } state_e;

endpackage

// File: rtl/game_sequencer_if.sv
// Bundle between the game sequencer and the player/alien datapath.
// master: sequencer side (takes game events and score, drives ticks, clears, HUD).
// slave: datapath side. Optional hiscore signal exists only when HISCORE_EN is defined.
interface game_sequencer_if;
  import game_pkg::*;

  logic                 start_debounced;
  logic                 ship_hit;
  logic                 aliens_landed;
  logic                 wave_cleared;
  logic [7:0]           score;
  logic                 enable;
  logic                 march;
  logic                 clear;
  logic                 clear_score;
  logic                 playing;
  logic [LIVES_W-1:0]   lives;
  logic [LEVEL_W-1:0]   level;
  logic [2:0]           state;
`ifdef HISCORE_EN
  logic [7:0]           hiscore;
`endif

  modport master (
    input  start_debounced, ship_hit, aliens_landed, wave_cleared, score,
`ifdef HISCORE_EN
    output hiscore,
`endif
    output enable, march, clear, clear_score, playing, lives, level, state
  );

  modport slave (
    output start_debounced, ship_hit, aliens_landed, wave_cleared, score,
`ifdef HISCORE_EN
    input  hiscore,
`endif
    input  enable, march, clear, clear_score, playing, lives, level, state
  );

endinterface

// File: rtl/game_sequencer_tick_divider.sv
// Free-running divider: enable_o is high for one cycle out of every DIV.
// Ports: clk_i, rst_i (sync, active-high), enable_o (high in the cycle the count wraps).
// No backpressure; runs regardless of game state.
module tick_divider #(
  parameter int DIV = 600000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic enable_o
);

  localparam int CNT_W = $clog2(DIV + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap     = (cnt_q == CNT_W'(DIV - 1));
  assign cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);
  assign enable_o = wrap;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game controller: phases attract/play/death/wave-clear/game-over, counts lives and level,
// and produces the 60 Hz enable tick and the level-dependent alien march strobe.
// Ports: clk_36MHz, reset (sync, active-high), bus (game_sequencer_if.master).
// State/lives/level/clear are registered: one cycle from input event to change.
// Optional HISCORE_EN adds a persistent hiscore register on the bus.
module game_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV    = 600000,
  parameter int LIVES_INIT  = 3,
  parameter int PAUSE_TICKS = 120,
  parameter int MARCH_BASE  = 30,
  parameter int MAX_LEVEL   = 7
) (
  input  logic                  clk_36MHz,
  input  logic                  reset,
  game_sequencer_if.master      bus
);

  localparam int PAUSE_W = $clog2(PAUSE_TICKS + 1);
  localparam int MARCH_W = $clog2(MARCH_BASE + 1);

  logic                 enable;
  state_e               state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [PAUSE_W-1:0]   pause_q, pause_d;
  logic [MARCH_W-1:0]   march_q, march_d;
  logic [MARCH_W-1:0]   march_lim;
  logic                 march_fire;
  logic                 clear_q, clear_d;
  logic                 clear_score_q, clear_score_d;
  logic                 playing_q, playing_d;

  tick_divider #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk_i    (clk_36MHz),
    .rst_i    (reset),
    .enable_o (enable)
  );

  // Higher levels march faster: one pulse every (MARCH_BASE - level) ticks.
  assign march_lim  = MARCH_W'(MARCH_BASE - 1) - MARCH_W'(level_q);
  assign march_fire = enable && (state_q == PLAY) && (march_q == march_lim);

  always_comb begin
    march_d = march_q;
    if (clear_q) begin
      march_d = '0;
    end else if (enable && (state_q == PLAY)) begin
      march_d = march_fire ? '0 : march_q + MARCH_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    pause_d = pause_q;

    case (state_q)
      IDLE, GAME_OVER: begin
        if (bus.start_debounced) begin
          state_d = NEW_GAME;
          lives_d = LIVES_W'(LIVES_INIT);
          level_d = '0;
        end
      end

      NEW_GAME: state_d = PLAY;

      PLAY: begin
        pause_d = '0;
        // Landing ends the game outright, even if the ship was also hit.
        if (bus.aliens_landed) begin
          state_d = GAME_OVER;
          lives_d = '0;
        end else if (bus.ship_hit) begin
          state_d = DEATH;
          lives_d = (lives_q != '0) ? lives_q - LIVES_W'(1) : '0;
        end else if (bus.wave_cleared) begin
          state_d = WAVE_DONE;
          level_d = (level_q >= LEVEL_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL)
                                                     : level_q + LEVEL_W'(1);
        end
      end

      DEATH, WAVE_DONE: begin
        if (enable) begin
          if (pause_q == PAUSE_W'(PAUSE_TICKS - 1)) begin
            pause_d = '0;
            if ((state_q == WAVE_DONE) || (lives_q != '0)) begin
              state_d = RESPAWN;
            end else begin
              state_d = GAME_OVER;
            end
          end else begin
            pause_d = pause_q + PAUSE_W'(1);
          end
        end
      end

      RESPAWN: state_d = PLAY;

      default: state_d = IDLE;
    endcase

    // Pulses are decoded from the next state so they line up with the state register.
    clear_d       = (state_d == NEW_GAME) || (state_d == RESPAWN);
    clear_score_d = (state_d == NEW_GAME);
    playing_d     = (state_d == PLAY);
  end

  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      state_q       <= IDLE;
      lives_q       <= '0;
      level_q       <= '0;
      pause_q       <= '0;
      march_q       <= '0;
      clear_q       <= 1'b0;
      clear_score_q <= 1'b0;
      playing_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      pause_q       <= pause_d;
      march_q       <= march_d;
      clear_q       <= clear_d;
      clear_score_q <= clear_score_d;
      playing_q     <= playing_d;
    end
  end

`ifdef HISCORE_EN
  logic [7:0] hiscore_q;

  // Score is captured on the cycle the game-over transition is taken.
  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      hiscore_q <= '0;
    end else if ((state_d == GAME_OVER) && (state_q != GAME_OVER) &&
                 (bus.score > hiscore_q)) begin
      hiscore_q <= bus.score;
    end
  end

  assign bus.hiscore = hiscore_q;
`endif

  assign bus.enable      = enable;
  assign bus.march       = march_fire;
  assign bus.clear       = clear_q;
  assign bus.clear_score = clear_score_q;
  assign bus.playing     = playing_q;
  assign bus.lives       = lives_q;
  assign bus.level       = level_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;
  import game_pkg::*;

  localparam int TICK_DIV    = 4;
  localparam int PAUSE_TICKS = 2;
  localparam int MARCH_BASE  = 5;
  localparam int LIVES_INIT  = 3;

  typedef struct packed {
    logic [2:0] state;
    logic [2:0] lives;
    logic [2:0] level;
    logic       playing;
    logic       clear;
    logic       clear_score;
  } snap_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  game_sequencer_if bus ();

  game_sequencer #(
    .TICK_DIV    (TICK_DIV),
    .LIVES_INIT  (LIVES_INIT),
    .PAUSE_TICKS (PAUSE_TICKS),
    .MARCH_BASE  (MARCH_BASE),
    .MAX_LEVEL   (7)
  ) dut (
    .clk_36MHz (clk),
    .reset     (reset),
    .bus       (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  snap_t      exp_q[$];
  logic [1:0] exp_bits_q[$];

  function automatic snap_t mk(input logic [2:0] st, input logic [2:0] lv,
                               input logic [2:0] lvl, input logic p,
                               input logic c, input logic cs);
    return {st, lv, lvl, p, c, cs};
  endfunction

  function automatic snap_t snap();
    return {bus.state, bus.lives, bus.level, bus.playing, bus.clear, bus.clear_score};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in a cycle whose enable is high (the current one if already so).
  task automatic wait_enable(input string tag);
    int n = 0;
    while (bus.enable !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.enable !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: enable timeout, enable=%b required 1", tag, bus.enable);
    end
  endtask

  task automatic test_reset();
    logic [1:0] got;
    logic [1:0] e;
    snap_t      s;
    reset = 1'b1;
    bus.start_debounced = 1'b0;
    bus.ship_hit = 1'b0;
    bus.aliens_landed = 1'b0;
    bus.wave_cleared = 1'b0;
    bus.score = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    s = snap();
    tests_run++;
    if (s !== snap_t'(0) || bus.enable !== 1'b0 || bus.march !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got snap=%h en=%b march=%b, required 000 0 0",
               s, bus.enable, bus.march);
    end
    for (int k = 1; k <= 12; k++) exp_bits_q.push_back({(k % 4) == 3, 1'b0});
    for (int k = 1; k <= 12; k++) begin
      tick();
      got = {bus.enable, bus.march};
      e = exp_bits_q.pop_front();
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL enable_period cyc%0d: got en/march=%b, required %b", k, got, e);
      end
    end
  endtask

  task automatic test_start(input logic hit_in_new_game);
    snap_t s;
    snap_t e;
    bus.start_debounced = 1'b1;
    exp_q.push_back(mk(NEW_GAME, 3'(LIVES_INIT), 3'd0, 1'b0, 1'b1, 1'b1));
    exp_q.push_back(mk(PLAY, 3'(LIVES_INIT), 3'd0, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 2; i++) begin
      tick();
      bus.start_debounced = 1'b0;
      bus.ship_hit = hit_in_new_game && (i == 0);
      s = snap();
      e = exp_q.pop_front();
      tests_run++;
      if (s !== e) begin
        tests_failed++;
        $display("FAIL start step%0d: got %h, required %h", i, s, e);
      end
    end
    bus.ship_hit = 1'b0;
  endtask

  // Assumes the march counter is at zero (first cycle of PLAY after a clear).
  task automatic test_march(input int lvl, input int n_enables);
    int   mcnt = 0;
    logic e;
    logic got;
    for (int i = 0; i < n_enables; i++) begin
      wait_enable("march");
      exp_bits_q.push_back({1'b0, mcnt == (MARCH_BASE - lvl - 1)});
      mcnt = (mcnt == (MARCH_BASE - lvl - 1)) ? 0 : mcnt + 1;
      got = bus.march;
      e = exp_bits_q.pop_front()[0];
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL march lvl%0d enable%0d: got %b, required %b", lvl, i, got, e);
      end
      tick();
    end
  endtask

  task automatic test_wave_clear();
    snap_t s;
    snap_t e;
    bus.wave_cleared = 1'b1;
    exp_q.push_back(mk(WAVE_DONE, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(WAVE_DONE, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(RESPAWN, 3'd3, 3'd1, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(PLAY, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      if (i == 2) wait_enable("wave_pause");
      tick();
      bus.wave_cleared = 1'b0;
      if (i == 0) wait_enable("wave_pause");
      s = snap();
      e = exp_q.pop_front();
      tests_run++;
      if (s !== e) begin
        tests_failed++;
        $display("FAIL wave step%0d: got %h, required %h", i, s, e);
      end
      if (i == 0) tick();
    end
  endtask

  task automatic test_lives();
    snap_t s;
    snap_t e;
    bus.start_debounced = 1'b1;
    exp_q.push_back(mk(PLAY, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0));
    tick();
    bus.start_debounced = 1'b0;
    s = snap();
    e = exp_q.pop_front();
    tests_run++;
    if (s !== e) begin
      tests_failed++;
      $display("FAIL start_ignored_in_play: got %h, required %h", s, e);
    end
    for (int i = 1; i <= 3; i++) begin
      bus.ship_hit = 1'b1;
      exp_q.push_back(mk(DEATH, 3'(3 - i), 3'd1, 1'b0, 1'b0, 1'b0));
      if (i < 3) begin
        exp_q.push_back(mk(RESPAWN, 3'(3 - i), 3'd1, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(PLAY, 3'(3 - i), 3'd1, 1'b1, 1'b0, 1'b0));
      end else begin
        exp_q.push_back(mk(GAME_OVER, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0));
      end
      for (int step = 0; step < ((i < 3) ? 3 : 2); step++) begin
        if (step == 1) begin
          wait_enable("death_pause");
          tick();
          wait_enable("death_pause");
        end
        tick();
        bus.ship_hit = 1'b0;
        s = snap();
        e = exp_q.pop_front();
        tests_run++;
        if (s !== e) begin
          tests_failed++;
          $display("FAIL lives hit%0d step%0d: got %h, required %h", i, step, s, e);
        end
      end
    end
    // Restart from GAME_OVER; a hit during NEW_GAME must be ignored.
    test_start(1'b1);
  endtask

  task automatic test_collide();
    snap_t s;
    snap_t e;
    bus.ship_hit = 1'b1;
    bus.aliens_landed = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(GAME_OVER, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.ship_hit = 1'b0;
      bus.aliens_landed = 1'b0;
      s = snap();
      e = exp_q.pop_front();
      tests_run++;
      if (s !== e) begin
        tests_failed++;
        $display("FAIL collide cyc%0d: got %h, required %h", i, s, e);
      end
    end
  endtask

  task automatic test_hit_over_wave();
    snap_t s;
    snap_t e;
    test_start(1'b0);
    bus.ship_hit = 1'b1;
    bus.wave_cleared = 1'b1;
    exp_q.push_back(mk(DEATH, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0));
    tick();
    bus.ship_hit = 1'b0;
    bus.wave_cleared = 1'b0;
    s = snap();
    e = exp_q.pop_front();
    tests_run++;
    if (s !== e) begin
      tests_failed++;
      $display("FAIL hit_over_wave: got %h, required %h", s, e);
    end
  endtask

`ifdef HISCORE_EN
  task automatic test_hiscore();
    logic [7:0] hs_q[$];
    logic [7:0] e;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    hs_q.push_back(8'd0);
    hs_q.push_back(8'd42);
    hs_q.push_back(8'd42);
    hs_q.push_back(8'd0);
    e = hs_q.pop_front();
    tests_run++;
    if (bus.hiscore !== e) begin
      tests_failed++;
      $display("FAIL hiscore_reset: got %0d, required %0d", bus.hiscore, e);
    end
    for (int g = 0; g < 2; g++) begin
      test_start(1'b0);
      bus.score = (g == 0) ? 8'd42 : 8'd10;
      bus.aliens_landed = 1'b1;
      tick();
      bus.aliens_landed = 1'b0;
      e = hs_q.pop_front();
      tests_run++;
      if (bus.hiscore !== e) begin
        tests_failed++;
        $display("FAIL hiscore game%0d: got %0d, required %0d", g, bus.hiscore, e);
      end
    end
    test_start(1'b0);
    bus.score = 8'd50;
    bus.ship_hit = 1'b1;
    tick();
    bus.ship_hit = 1'b0;
    wait_enable("hiscore_pause");
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    e = hs_q.pop_front();
    tests_run++;
    if (bus.hiscore !== e || snap() !== snap_t'(0)) begin
      tests_failed++;
      $display("FAIL hiscore_midpause_reset: got hs=%0d snap=%h, required %0d 000",
               bus.hiscore, snap(), e);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start(1'b0);
    test_march(0, 12);
    test_wave_clear();
    test_march(1, 8);
    test_lives();
    test_collide();
    test_hit_over_wave();
`ifdef HISCORE_EN
    test_hiscore();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 200000", $time);
    $fatal(1);
  end

endmodule
